char_write_arbiter: RTL

Owns the single write port of `char_buffer`. It arbitrates that port between the `command_handler` per-character writes and an internal fill engine that sequences bulk writes of one character: clear screen, clear to end of line, and blanking the new bottom line after a scroll. Fill requests also come from `command_handler`. The block sits between `command_handler` and `char_buffer`, on the `clk_usb` domain.

---
 rtl/vt52_pkg.sv | 16 +
 rtl/addr_wrap_inc.sv | 19 +
 rtl/char_write_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/vt52_pkg.sv
// Shared VT52 terminal constants: buffer geometry and
// the character write arbiter state encoding.
package vt52_pkg;

  localparam int ADDR_BITS = 11;
  localparam int COLS      = 80;
  localparam int ROWS      = 25;
  localparam int BUF_CHARS = COLS * ROWS;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } arb_state_e;

endpackage

// File: rtl/addr_wrap_inc.sv
// Combinational (addr+1) mod BUF_CHARS step over the
// circular character buffer layout.
module addr_wrap_inc #(
  parameter int ADDR_BITS = vt52_pkg::ADDR_BITS,
  parameter int BUF_CHARS = vt52_pkg::BUF_CHARS
) (
  input  logic [ADDR_BITS-1:0] addr,
  output logic [ADDR_BITS-1:0] addr_next
);

  localparam logic [ADDR_BITS-1:0] LAST =
    ADDR_BITS'(BUF_CHARS - 1);

  always_comb begin
    addr_next = (addr == LAST) ? '0
              : addr + ADDR_BITS'(1);
  end

endmodule

// File: rtl/char_write_arbiter.sv
// Arbitrates the char_buffer write port between single writes
// and bulk fills; FILL_ABORT_EN adds a fill_abort input.
module char_write_arbiter #(
  parameter int ADDR_BITS = vt52_pkg::ADDR_BITS,
  parameter int BUF_CHARS = vt52_pkg::BUF_CHARS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           cmd_char,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [7:0]           fill_char,
  input  logic [ADDR_BITS-1:0] fill_addr,
  input  logic [ADDR_BITS-1:0] fill_len,
  input  logic                 fill_start,
`ifdef FILL_ABORT_EN
  input  logic                 fill_abort,
`endif
  output logic                 fill_ready,
  output logic                 fill_done,
  output logic [7:0]           buf_char,
  output logic [ADDR_BITS-1:0] buf_addr,
  output logic                 buf_wen
);

  import vt52_pkg::*;

  localparam logic [ADDR_BITS-1:0] MAX_LEN =
    ADDR_BITS'(BUF_CHARS);

  arb_state_e           state;
  logic [ADDR_BITS-1:0] cnt;
  logic [ADDR_BITS-1:0] cur_addr;
  logic [ADDR_BITS-1:0] inc_in;
  logic [ADDR_BITS-1:0] inc_out;
  logic [ADDR_BITS-1:0] len_c;
  logic [7:0]           fill_ch;
  logic                 stop;

  assign fill_ready = (state == IDLE);
  assign cmd_ready  = fill_ready && !fill_start;
  assign len_c      = (fill_len > MAX_LEN) ? MAX_LEN
                    : fill_len;
  // First write is issued at accept, so step fill_addr then.
  assign inc_in     = fill_ready ? fill_addr : cur_addr;

`ifdef FILL_ABORT_EN
  assign stop = (cnt == '0) || fill_abort;
`else
  assign stop = (cnt == '0);
`endif

  addr_wrap_inc #(
    .ADDR_BITS (ADDR_BITS),
    .BUF_CHARS (BUF_CHARS)
  ) u_inc (
    .addr      (inc_in),
    .addr_next (inc_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_addr  <= '0;
      fill_ch   <= '0;
      buf_char  <= '0;
      buf_addr  <= '0;
      buf_wen   <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      buf_wen   <= 1'b0;
      fill_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fill_start) begin
            fill_ch <= fill_char;
            if (len_c == '0) begin
              state     <= DONE;
              fill_done <= 1'b1;
            end else begin
              state    <= FILL;
              buf_wen  <= 1'b1;
              buf_addr <= fill_addr;
              buf_char <= fill_char;
              cur_addr <= inc_out;
              cnt      <= len_c - ADDR_BITS'(1);
            end
          end else if (cmd_valid) begin
            buf_wen  <= 1'b1;
            buf_addr <= cmd_addr;
            buf_char <= cmd_char;
          end
        end
        FILL: begin
          if (stop) begin
            state     <= DONE;
            fill_done <= 1'b1;
          end else begin
            buf_wen  <= 1'b1;
            buf_addr <= cur_addr;
            buf_char <= fill_ch;
            cur_addr <= inc_out;
            cnt      <= cnt - ADDR_BITS'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
